// File: rtl/nv_nvdla_sdp_pack_arb.sv
// Two-requester weighted round-robin arbiter feeding the SDP wide-to-narrow pack unit.
// A grant stays locked until the burst's last word, so the pack unit never sees interleaved bursts.
module nv_nvdla_sdp_pack_arb #(
    parameter int unsigned IW = 512,
    parameter int unsigned WW = 4
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic [WW-1:0] cfg_weight0,
    input  logic [WW-1:0] cfg_weight1,
    input  logic          req0_pvld,
    input  logic [IW-1:0] req0_pdata,
    input  logic          req0_last,
    output logic          req0_prdy,
    input  logic          req1_pvld,
    input  logic [IW-1:0] req1_pdata,
    input  logic          req1_last,
    output logic          req1_prdy,
    output logic          out_pvld,
    output logic [IW-1:0] out_pdata,
    output logic          out_id,
    output logic          out_last,
    input  logic          out_prdy,
    output logic          arb_idle
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e        state;
    logic          lock_id;
    logic          ptr;
    logic [WW-1:0] bcnt;

    logic          stage_en;
    logic          gnt0;
    logic          gnt1;
    logic          acc0;
    logic          acc1;
    logic          acc;
    logic          acc_id;
    logic          acc_last;
    logic [WW-1:0] w_raw;
    logic [WW:0]   w_eff;
    logic [WW:0]   bcnt_inc;

    assign stage_en = !out_pvld | out_prdy;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == StLock) begin
            gnt0 = !lock_id;
            gnt1 = lock_id;
        end else if (req0_pvld && req1_pvld) begin
            gnt0 = !ptr;
            gnt1 = ptr;
        end else begin
            gnt0 = req0_pvld;
            gnt1 = req1_pvld;
        end
    end

    // Ready is offered on grant alone, so a locked requester that drops pvld leaves a bubble.
    assign req0_prdy = gnt0 & stage_en;
    assign req1_prdy = gnt1 & stage_en;

    assign acc0     = req0_pvld & req0_prdy;
    assign acc1     = req1_pvld & req1_prdy;
    assign acc      = acc0 | acc1;
    assign acc_id   = acc1;
    assign acc_last = acc1 ? req1_last : req0_last;

    assign w_raw    = acc_id ? cfg_weight1 : cfg_weight0;
    assign w_eff    = (w_raw == '0) ? (WW+1)'(1) : {1'b0, w_raw};
    assign bcnt_inc = {1'b0, bcnt} + (WW+1)'(1);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= StIdle;
            lock_id  <= 1'b0;
            ptr      <= 1'b0;
            bcnt     <= '0;
            out_pvld <= 1'b0;
            out_id   <= 1'b0;
            out_last <= 1'b0;
        end else begin
            if (acc) begin
                if (acc_last) begin
                    state <= StIdle;
                    // A win by a non-pointer requester hands the pointer over unconditionally.
                    if ((acc_id != ptr) || (bcnt_inc >= w_eff)) begin
                        ptr  <= !acc_id;
                        bcnt <= '0;
                    end else begin
                        bcnt <= bcnt_inc[WW-1:0];
                    end
                end else begin
                    state   <= StLock;
                    lock_id <= acc_id;
                end
            end
            if (stage_en) begin
                out_pvld <= acc;
                if (acc) begin
                    out_id   <= acc_id;
                    out_last <= acc_last;
                end
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (acc) begin
            out_pdata <= acc_id ? req1_pdata : req0_pdata;
        end
    end

    assign arb_idle = (state == StIdle) & !out_pvld;

endmodule

// File: tb/tb_nv_nvdla_sdp_pack_arb.sv
// Scoreboard bench for the SDP pack arbiter: random words per requester, WRR burst-order model,
// a pack-unit backpressure model and async reset mid-burst.
module tb_nv_nvdla_sdp_pack_arb;
    localparam int IW = 512;
    localparam int WW = 4;
    localparam int BUDGET = 2000;

    typedef struct packed {
        logic          last;
        logic [IW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] w0 = '0;
    logic [WW-1:0] w1 = '0;
    logic [1:0]    pvld = '0;
    logic [1:0]    plast = '0;
    logic [1:0]    prdy;
    logic [IW-1:0] pdata [2];
    logic          out_pvld;
    logic [IW-1:0] out_pdata;
    logic          out_id;
    logic          out_last;
    logic          out_prdy = 1'b1;
    logic          arb_idle;

    word_t src_q [2][$];
    word_t exp_q [2][$];
    int    exp_id_q [$];

    int errors = 0;
    int checks = 0;
    int prdy_mode = 0;
    int stall_pct = 0;
    int pause_after [2] = '{-1, -1};
    int pause [2] = '{0, 0};
    int acc_cnt [2] = '{0, 0};
    int acc_total = 0;
    int last_acc_cyc = 0;
    int cyc = 0;
    int beats_left = 0;
    bit lock_chk = 0;
    bit spacing_chk = 0;

    nv_nvdla_sdp_pack_arb #(.IW(IW), .WW(WW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rst_n),
        .cfg_weight0    (w0),
        .cfg_weight1    (w1),
        .req0_pvld      (pvld[0]),
        .req0_pdata     (pdata[0]),
        .req0_last      (plast[0]),
        .req0_prdy      (prdy[0]),
        .req1_pvld      (pvld[1]),
        .req1_pdata     (pdata[1]),
        .req1_last      (plast[1]),
        .req1_prdy      (prdy[1]),
        .out_pvld       (out_pvld),
        .out_pdata      (out_pdata),
        .out_id         (out_id),
        .out_last       (out_last),
        .out_prdy       (out_prdy),
        .arb_idle       (arb_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [IW-1:0] rand_word();
        logic [IW-1:0] r;
        for (int i = 0; i < IW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic add_burst(input int g, input int len);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.data = rand_word();
            w.last = (i == len - 1);
            src_q[g].push_back(w);
            exp_q[g].push_back(w);
        end
    endtask

    // Expected burst-owner order when both requesters hold pending bursts from the start.
    task automatic wrr_expect(input int wa, input int wb, input int na, input int nb);
        int n [2];
        int w [2];
        int t;
        n[0] = na;
        n[1] = nb;
        w[0] = (wa < 1) ? 1 : wa;
        w[1] = (wb < 1) ? 1 : wb;
        t = 0;
        while (n[0] + n[1] > 0) begin
            for (int k = 0; k < w[t] && n[t] > 0; k++) begin
                exp_id_q.push_back(t);
                n[t]--;
            end
            t = 1 - t;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            src_q[g].delete();
            exp_q[g].delete();
            acc_cnt[g] = 0;
            pause[g] = 0;
            pause_after[g] = -1;
        end
        exp_id_q.delete();
        acc_total = 0;
        lock_chk = 0;
        spacing_chk = 0;
        #1;
        check("reset_out_pvld", out_pvld, 0);
        check("reset_arb_idle", arb_idle, 1);
        check("reset_out_id", out_id, 0);
        check("reset_out_last", out_last, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        apply_reset();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) > 0 &&
               n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL %s_timeout: %0d words pending, required 0",
                     name, exp_q[0].size() + exp_q[1].size());
        end
        repeat (6) @(posedge clk);
        #2;
        check({name, "_arb_idle"}, arb_idle, 1);
        check({name, "_order_consumed"}, exp_id_q.size(), 0);
    endtask

    initial begin : driver
        logic hs [2];
        logic ohs;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) hs[g] = rst_n && pvld[g] && prdy[g];
            ohs = rst_n && out_pvld && out_prdy;
            if (lock_chk && acc_cnt[0] >= 1 && acc_cnt[0] < 4) check("lock_hold_req1_prdy", prdy[1], 0);
            @(posedge clk);
            #1;
            cyc++;
            if (hs[0] || hs[1]) begin
                check("accept_to_out_pvld", out_pvld, 1);
                if (spacing_chk && acc_total >= 2) check("accept_spacing", (cyc - last_acc_cyc) >= 4, 1);
                last_acc_cyc = cyc;
                acc_total++;
            end
            for (int g = 0; g < 2; g++) begin
                if (hs[g]) begin
                    void'(src_q[g].pop_front());
                    acc_cnt[g]++;
                    if (acc_cnt[g] == pause_after[g]) pause[g] = 2;
                end
                if (pause[g] > 0) begin
                    pvld[g] = 1'b0;
                    pause[g]--;
                end else begin
                    pvld[g] = (src_q[g].size() > 0) && ($urandom_range(99) >= stall_pct);
                end
                if (src_q[g].size() > 0) begin
                    pdata[g] = src_q[g][0].data;
                    plast[g] = src_q[g][0].last;
                end
            end
            // Pack unit at ratio 4: ready when empty or on its final narrow beat.
            if (!rst_n) beats_left = 0;
            else begin
                if (beats_left > 0) beats_left--;
                if (ohs) beats_left = 4;
            end
            case (prdy_mode)
                0: out_prdy = 1'b1;
                1: out_prdy = (beats_left <= 1);
                default: out_prdy = 1'($urandom_range(1));
            endcase
        end
    end

    initial begin : monitor
        logic          in_burst;
        logic          cur_id;
        logic          hold;
        logic [IW-1:0] hd;
        logic          hid;
        logic          hlast;
        word_t         w;
        in_burst = 0;
        cur_id = 0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_burst = 0;
                hold = 0;
                continue;
            end
            if (hold) begin
                check("stall_out_pvld_held", out_pvld, 1);
                check("stall_out_pdata_stable", out_pdata, hd);
                check("stall_out_id_stable", out_id, hid);
                check("stall_out_last_stable", out_last, hlast);
            end
            hold = out_pvld && !out_prdy;
            hd = out_pdata;
            hid = out_id;
            hlast = out_last;
            if (out_pvld && out_prdy) begin
                if (in_burst) check("no_interleave_id", out_id, cur_id);
                else if (exp_id_q.size() > 0) check("burst_order_id", out_id, exp_id_q.pop_front());
                if (exp_q[out_id].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: id %0d delivered a word, none pending", out_id);
                end else begin
                    w = exp_q[out_id].pop_front();
                    check("out_pdata", out_pdata, w.data);
                    check("out_last", out_last, w.last);
                end
                cur_id = out_id;
                in_burst = !out_last;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int rem;
        int len;
        // Single requester, 3-word burst.
        w0 = 4'd1;
        w1 = 4'd1;
        do_reset();
        add_burst(0, 3);
        exp_id_q.push_back(0);
        wait_done("single");

        // Equal weights, 2-word bursts, both saturated.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_burst(0, 2);
            add_burst(1, 2);
        end
        wrr_expect(1, 1, 4, 4);
        wait_done("alt_1_1");

        // Weights 3/1 with single-word bursts.
        w0 = 4'd3;
        w1 = 4'd1;
        do_reset();
        for (int i = 0; i < 6; i++) add_burst(0, 1);
        for (int i = 0; i < 2; i++) add_burst(1, 1);
        wrr_expect(3, 1, 6, 2);
        wait_done("wrr_3_1");

        // Weight 0 behaves as 1.
        w0 = 4'd0;
        w1 = 4'd2;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_burst(0, 1);
            add_burst(1, 1);
        end
        wrr_expect(0, 2, 4, 4);
        wait_done("wrr_0_2");

        // Lock hold across a requester bubble.
        w0 = 4'd1;
        w1 = 4'd1;
        do_reset();
        pause_after[0] = 2;
        lock_chk = 1;
        add_burst(0, 4);
        add_burst(1, 1);
        exp_id_q.push_back(0);
        exp_id_q.push_back(1);
        wait_done("lock_hold");
        lock_chk = 0;

        // Pack-unit backpressure at ratio 4, 16 words total.
        do_reset();
        prdy_mode = 1;
        spacing_chk = 1;
        for (int g = 0; g < 2; g++) begin
            rem = 8;
            while (rem > 0) begin
                len = $urandom_range(4, 1);
                if (len > rem) len = rem;
                add_burst(g, len);
                rem -= len;
            end
        end
        wait_done("ratio4");
        spacing_chk = 0;

        // Random weights, stalls and downstream readiness.
        w0 = 4'($urandom_range(3));
        w1 = 4'($urandom_range(3));
        do_reset();
        prdy_mode = 2;
        stall_pct = 30;
        for (int i = 0; i < 10; i++) begin
            add_burst(0, $urandom_range(4, 1));
            add_burst(1, $urandom_range(4, 1));
        end
        wait_done("random");

        // Async reset while requester 1 holds the lock after 1 of 3 words.
        prdy_mode = 0;
        stall_pct = 0;
        w0 = 4'd1;
        w1 = 4'd1;
        do_reset();
        add_burst(1, 3);
        n = 0;
        while (acc_cnt[1] < 1 && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reset_lock_reached", acc_cnt[1], 1);
        #1;
        check("mid_lock_prereset_idle", arb_idle, 0);
        apply_reset();
        add_burst(0, 1);
        add_burst(1, 1);
        exp_id_q.push_back(0);
        exp_id_q.push_back(1);
        wait_done("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
